// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch front end.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_t;

   localparam int          INSTR_W   = 32;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
   localparam int          PC_INCR   = 4;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory request/response and instruction handshake bundle of the fetch unit.
// The master side is the fetch unit; the slave side is memory plus control unit.
interface fetch_unit_if #(
   parameter int ADDR_WIDTH = 32
);
   import fetch_pkg::*;

   logic                  imem_req;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic                  imem_rvalid;
   logic [INSTR_W-1:0]    imem_rdata;
   logic [INSTR_W-1:0]    instr;
   logic                  instr_valid;
   logic                  instr_ready;
   logic                  PCsrc;
   logic [ADDR_WIDTH-1:0] ImmOp;
   logic [ADDR_WIDTH-1:0] PC;
   logic                  fetch_err;

   modport master (
      output imem_req, imem_addr,
      input  imem_rvalid, imem_rdata,
      output instr, instr_valid,
      input  instr_ready, PCsrc, ImmOp,
      output PC, fetch_err
   );

   modport slave (
      input  imem_req, imem_addr,
      output imem_rvalid, imem_rdata,
      input  instr, instr_valid,
      output instr_ready, PCsrc, ImmOp,
      input  PC, fetch_err
   );

endinterface

// File: rtl/fetch_unit_pc_next_calc.sv
// Next-PC arithmetic: branch target or sequential increment, word aligned.
module pc_next_calc
   import fetch_pkg::*;
#(
   parameter int ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] PC,
   input  logic [ADDR_WIDTH-1:0] ImmOp,
   input  logic                  PCsrc,
   output logic [ADDR_WIDTH-1:0] pc_next
);

   logic [ADDR_WIDTH-1:0] sum;

   // Wraps modulo 2^ADDR_WIDTH; low bits cleared so odd offsets cannot misalign.
   always_comb begin
      sum     = PC + (PCsrc ? ImmOp : ADDR_WIDTH'(PC_INCR));
      pc_next = {sum[ADDR_WIDTH-1:2], 2'b00};
   end

endmodule

// File: rtl/fetch_unit.sv
// Sequential instruction fetch: PC register, one-shot memory request, valid/ready output.
// Optional WAIT watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int                    ADDR_WIDTH     = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
   parameter int                    TIMEOUT_CYCLES = 16
) (
   input logic          clk,
   input logic          rst_n,
   fetch_unit_if.master bus
);

   fetch_state_t          state_q;
   logic [ADDR_WIDTH-1:0] pc_q;
   logic [ADDR_WIDTH-1:0] pc_next;
   logic [INSTR_W-1:0]    instr_q;
   logic                  valid_q;
   logic                  req_q;

   if ((RESET_PC[1:0] != 2'b00) || (TIMEOUT_CYCLES < 1)) begin : g_bad_param
      $error("fetch_unit: RESET_PC must be word aligned and TIMEOUT_CYCLES positive");
   end

   pc_next_calc #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_pc_next (
      .PC      (pc_q),
      .ImmOp   (bus.ImmOp),
      .PCsrc   (bus.PCsrc),
      .pc_next (pc_next)
   );

`ifdef FETCH_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] wait_cnt;
   logic             err_q;

   // Watchdog variant: an unanswered WAIT reissues the same PC and latches the error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         pc_q     <= RESET_PC;
         instr_q  <= NOP_INSTR;
         valid_q  <= 1'b0;
         req_q    <= 1'b0;
         wait_cnt <= '0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= REQ;
               req_q   <= 1'b1;
            end
            REQ: begin
               state_q  <= WAIT;
               req_q    <= 1'b0;
               wait_cnt <= '0;
            end
            WAIT: begin
               if (bus.imem_rvalid) begin
                  instr_q <= bus.imem_rdata;
                  valid_q <= 1'b1;
                  state_q <= HOLD;
               end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                  err_q   <= 1'b1;
                  state_q <= REQ;
                  req_q   <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            HOLD: begin
               if (bus.instr_ready) begin
                  pc_q    <= pc_next;
                  valid_q <= 1'b0;
                  state_q <= REQ;
                  req_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.fetch_err = err_q;
`else
   // Plain variant: WAIT holds until memory answers, however long that takes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         valid_q <= 1'b0;
         req_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= REQ;
               req_q   <= 1'b1;
            end
            REQ: begin
               state_q <= WAIT;
               req_q   <= 1'b0;
            end
            WAIT: begin
               if (bus.imem_rvalid) begin
                  instr_q <= bus.imem_rdata;
                  valid_q <= 1'b1;
                  state_q <= HOLD;
               end
            end
            HOLD: begin
               if (bus.instr_ready) begin
                  pc_q    <= pc_next;
                  valid_q <= 1'b0;
                  state_q <= REQ;
                  req_q   <= 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               req_q   <= 1'b0;
            end
         endcase
      end
   end

   assign bus.fetch_err = 1'b0;
`endif

   assign bus.imem_req    = req_q;
   assign bus.imem_addr   = pc_q;
   assign bus.PC          = pc_q;
   assign bus.instr       = instr_q;
   assign bus.instr_valid = valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized self-checking bench for fetch_unit: the bench plays memory and control unit
// and tracks the expected PC sequence with plain arithmetic.
module tb_fetch_unit;

   logic clk;
   logic rst_n;

   fetch_unit_if #(.ADDR_WIDTH(32)) bus ();

   fetch_unit #(
      .ADDR_WIDTH     (32),
      .RESET_PC       (32'h0000_0000),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          checkCount;
   int          errorCount;
   logic [31:0] modelPc;
   logic [31:0] expErr;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_req"},   bus.imem_req,    32'd0);
      checkOutput({tag, "_addr"},  bus.imem_addr,   32'h0);
      checkOutput({tag, "_pc"},    bus.PC,          32'h0);
      checkOutput({tag, "_instr"}, bus.instr,       32'h0000_0013);
      checkOutput({tag, "_valid"}, bus.instr_valid, 32'd0);
      checkOutput({tag, "_err"},   bus.fetch_err,   32'd0);
   endtask

   // Called in the REQ cycle; runs one fetch to acceptance and leaves the bench in the next REQ cycle.
   task automatic applyStimulus(input int lat, input int holdLow, input bit src,
                                input logic [31:0] imm, input logic [31:0] data);
      logic [31:0] target;
      checkOutput("req_high",   bus.imem_req,    32'd1);
      checkOutput("req_addr",   bus.imem_addr,   modelPc);
      checkOutput("req_pc",     bus.PC,          modelPc);
      checkOutput("req_valid",  bus.instr_valid, 32'd0);
      checkOutput("fetch_err",  bus.fetch_err,   expErr);
      step();
      checkOutput("req_pulse",  bus.imem_req,    32'd0);
      for (int i = 1; i < lat; i++) begin
         bus.instr_ready = 1'($urandom_range(0, 1));
         step();
         checkOutput("wait_valid", bus.instr_valid, 32'd0);
         checkOutput("wait_req",   bus.imem_req,    32'd0);
      end
      bus.instr_ready = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = data;
      step();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = $urandom;
      checkOutput("hold_valid", bus.instr_valid, 32'd1);
      checkOutput("hold_instr", bus.instr,       data);
      for (int i = 0; i < holdLow; i++) begin
         bus.imem_rvalid = 1'($urandom_range(0, 1));
         bus.imem_rdata  = $urandom;
         bus.PCsrc       = 1'($urandom_range(0, 1));
         bus.ImmOp       = $urandom;
         step();
         checkOutput("stall_valid", bus.instr_valid, 32'd1);
         checkOutput("stall_instr", bus.instr,       data);
         checkOutput("stall_pc",    bus.PC,          modelPc);
         checkOutput("stall_req",   bus.imem_req,    32'd0);
      end
      bus.imem_rvalid = 1'b0;
      bus.instr_ready = 1'b1;
      bus.PCsrc       = src;
      bus.ImmOp       = imm;
      step();
      bus.instr_ready = 1'b0;
      bus.PCsrc       = 1'($urandom_range(0, 1));
      bus.ImmOp       = $urandom;
      target  = src ? (modelPc + imm) : (modelPc + 32'd4);
      modelPc = target & 32'hFFFF_FFFC;
      checkOutput("accept_valid", bus.instr_valid, 32'd0);
      checkOutput("accept_instr", bus.instr,       data);
   endtask

   initial begin
      checkCount      = 0;
      errorCount      = 0;
      modelPc         = 32'h0;
      expErr          = 32'd0;
      rst_n           = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = '0;
      bus.instr_ready = 1'b0;
      bus.PCsrc       = 1'b0;
      bus.ImmOp       = '0;

      #12;
      checkResetValues("reset");
      #10;
      rst_n = 1'b1;
      #1;
      checkOutput("idle_req", bus.imem_req, 32'd0);
      step();

      applyStimulus(1, 0, 1'b0, 32'h0, 32'h0050_0093);
      for (int i = 0; i < 3; i++) applyStimulus(1, 0, 1'b0, $urandom, $urandom);
      checkOutput("seq_pc", modelPc, 32'h10);
      applyStimulus(1, 0, 1'b1, 32'hFFFF_FFF8, $urandom);
      applyStimulus(2, 0, 1'b0, $urandom, $urandom);
      applyStimulus(1, 0, 1'b0, $urandom, $urandom);
      applyStimulus(1, 0, 1'b1, 32'h0000_0006, $urandom);
      applyStimulus(2, 5, 1'b0, $urandom, $urandom);

      applyStimulus(1, 1, 1'b1, 32'hFFFF_FFFC - modelPc, $urandom);
      applyStimulus(1, 0, 1'b0, $urandom, $urandom);

      for (int i = 0; i < 20; i++) begin
         applyStimulus(int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), $urandom, $urandom);
      end

`ifdef FETCH_TIMEOUT_EN
      checkOutput("to_req", bus.imem_req, 32'd1);
      for (int i = 0; i < 17; i++) step();
      expErr = 32'd1;
      checkOutput("to_err",  bus.fetch_err, expErr);
      checkOutput("to_req2", bus.imem_req,  32'd1);
      checkOutput("to_addr", bus.imem_addr, modelPc);
      applyStimulus(1, 0, 1'b0, $urandom, $urandom);
`else
      applyStimulus(20, 0, 1'b0, $urandom, $urandom);
`endif

      applyStimulus(1, 0, 1'b1, 32'h40 - modelPc, $urandom);
      checkOutput("mid_addr", bus.imem_addr, 32'h40);
      step();
      #2;
      rst_n           = 1'b0;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = 32'hDEAD_BEEF;
      #1;
      checkResetValues("async");
      @(negedge clk);
      rst_n = 1'b1;
      step();
      bus.imem_rvalid = 1'b0;
      modelPc = 32'h0;
      expErr  = 32'd0;
      checkOutput("post_valid", bus.instr_valid, 32'd0);
      checkOutput("post_instr", bus.instr,       32'h0000_0013);
      applyStimulus(1, 0, 1'b0, $urandom, $urandom);

      $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Sequential instruction-fetch front end for the team21 RISC-V core. It holds the program counter, requests instruction words from instruction memory over a request/response handshake, and presents each word to the control unit with a valid/ready handshake. It consumes the control unit's `PCsrc` and the immediate `ImmOp` to form the next PC once the current instruction is accepted.

## Interface
Parameters:
- `ADDR_WIDTH`, default 32: PC and memory address width.
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be word-aligned.
- `TIMEOUT_CYCLES`, default 16: watchdog limit in the WAIT state. Used only with `FETCH_TIMEOUT_EN`.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `imem_req` output 1: fetch request, held for exactly one cycle per fetch.
- `imem_addr` output ADDR_WIDTH: fetch address, equal to `PC` while `imem_req` is high.
- `imem_rvalid` input 1: memory response valid.
- `imem_rdata` input 32: memory response word.
- `instr` output 32: registered instruction presented to the control unit.
- `instr_valid` output 1: `instr` holds a fetched word.
- `instr_ready` input 1: the downstream stage has consumed `instr`.
- `PCsrc` input 1: branch-taken from the control unit; sampled only on acceptance.
- `ImmOp` input ADDR_WIDTH: sign-extended branch offset; sampled only on acceptance.
- `PC` output ADDR_WIDTH: address of the current/pending instruction.
- `fetch_err` output 1: sticky watchdog flag. Tied 0 without `FETCH_TIMEOUT_EN`.

## Operation
FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE: entered on reset. Moves unconditionally to REQ on the next clock.
- REQ: `imem_req`=1 and `imem_addr`=`PC`. Moves to WAIT.
- WAIT: on `imem_rvalid`, registers `imem_rdata` into `instr` and moves to HOLD. Otherwise it stays in WAIT.
- HOLD: `instr_valid`=1. On `instr_ready`, PC takes the next-PC value and the FSM moves to REQ.
- Next PC is `PC+ImmOp` when `PCsrc`=1, else `PC+4`. Arithmetic is modulo 2^ADDR_WIDTH, so 32'hFFFF_FFFC+4 gives 0. Bits [1:0] of the result are forced to 0.
- `imem_rvalid` outside WAIT is ignored. `instr_ready` outside HOLD is ignored. `PCsrc` and `ImmOp` are don't-care outside the HOLD-accept cycle.
- `instr` keeps its last value after acceptance until the next response arrives.
- Reset is asynchronous and takes effect immediately in any state:
  - FSM goes to IDLE and PC to `RESET_PC`.
  - `instr` resets to the NOP value 32'h0000_0013.
  - `instr_valid`, `imem_req` and `fetch_err` reset to 0.
  - `imem_addr` resets to `RESET_PC`.
- Instruction memory shares `rst_n`. A response in flight when reset asserts is therefore discarded.

## Timing
- `imem_req` is high for exactly one cycle. Memory responds one or more cycles later.
- Minimum request-to-`instr_valid` latency is 2 cycles: REQ, WAIT with `rvalid`, then HOLD.
- Minimum throughput is one instruction per 3 cycles, assuming `instr_ready` is already high in HOLD.
- `instr_valid` rises the cycle after `rvalid` is sampled. It falls the cycle after acceptance.
- The first fetch after reset release issues `imem_req` on the second rising edge.

## Configuration
- Macro `FETCH_TIMEOUT_EN`.
- Defined:
  - A counter runs in WAIT.
  - If WAIT persists for `TIMEOUT_CYCLES` cycles with no `rvalid`, `fetch_err` is set (sticky until reset) and the FSM returns to REQ to reissue the same `PC`.
  - The counter clears on entering WAIT.
- Undefined: no counter, `fetch_err` is constant 0, and WAIT lasts indefinitely.

## Structure
- Package `fetch_pkg`:
  - state enum `fetch_state_t`
  - `INSTR_W`=32
  - `NOP_INSTR`=32'h0000_0013
  - `PC_INCR`=4
- One combinational sub-module, `pc_next_calc`. Inputs: `PC`, `ImmOp`, `PCsrc`. Output: the aligned next PC. It is shared with future branch-prediction work.

## Test plan
- Reset release, memory with 1-cycle latency: `imem_req` at 32'h0. `rdata`=32'h00500093 gives `instr_valid` 2 cycles after `req`, with `instr`=32'h00500093.
- `instr_ready` held high, `PCsrc`=0: fetch addresses run 0, 4, 8, 12, with one request every 3 cycles.
- HOLD at PC=32'h10 with `PCsrc`=1 and `ImmOp`=32'hFFFF_FFF8: next `imem_addr`=32'h08. With `ImmOp`=6, next `imem_addr`=32'h14 (aligned).
- `instr_ready` low for 5 cycles in HOLD, with stray `imem_rvalid` pulses: `instr` and `PC` stay unchanged and no new request is issued.
- `rst_n` asserted mid-WAIT at PC=32'h40: outputs immediately return to reset values. The late response is ignored, and the first post-reset fetch goes to `RESET_PC`.
- `FETCH_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16, no response: `fetch_err`=1 after 16 WAIT cycles and `imem_req` reissues the same `PC`. A subsequent response then completes normally while `fetch_err` stays 1.
